// File: rtl/crc4fsk_pkg.sv
// Shared constants and state type for the CRC-8 / 4FSK transmit path.
package crc4fsk_pkg;
  localparam logic [7:0] CRC_POLY    = 8'h07;
  localparam int         CW_W        = 16;
  localparam int         SYM_W       = 2;
  localparam int         SYMS_PER_CW = 8;

  typedef enum logic {IDLE, SEND} tx_state_t;
endpackage

// File: rtl/crc8_encoder_strict_add.sv
// Combinational CRC-8 encoder (poly 0x07, init 0), codeword = {data, crc}; zero latency.
module crc8_encoder_strict_add
  import crc4fsk_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [K-1:0]   data,
  output logic [K+7:0]   codeword
);

  logic [7:0] w_crc;

  // Bit-serial MSB-first division, unrolled; the shift register is the remainder.
  always_comb begin
    w_crc = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (w_crc[7] ^ data[i]) w_crc = {w_crc[6:0], 1'b0} ^ CRC_POLY;
      else                    w_crc = {w_crc[6:0], 1'b0};
    end
    codeword = {data, w_crc};
  end

endmodule

// File: rtl/crc8_fsk_tx_ctrl.sv
// Encodes one byte into a 16-bit CRC-8 codeword and plays it out as eight 2-bit symbols.
// First symbol the cycle after accept; in_ready only in IDLE or the final symbol clock.
module crc8_fsk_tx_ctrl
  import crc4fsk_pkg::*;
#(
  parameter int SYM_CYCLES = 4,
  parameter int K          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [K-1:0]     in_data,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym,
  output logic             sym_first,
  output logic             tx_done,
  output logic             busy
);

  localparam int                CYC_W    = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(SYM_CYCLES - 1);
  localparam logic [2:0]        IDX_LAST = 3'(SYMS_PER_CW - 1);

  tx_state_t        r_state, w_next;
  logic [CW_W-1:0]  r_cw;
  logic [CW_W-1:0]  w_cw;
  logic [2:0]       r_sym_idx;
  logic [CYC_W-1:0] r_cyc;
  logic             w_last;
  logic             w_accept;
  logic [SYM_W-1:0] w_syms [SYMS_PER_CW];

  crc8_encoder_strict_add #(.K(K)) u_enc (
    .data     (in_data),
    .codeword (w_cw)
  );

  // Symbol 0 is the MSB pair of the codeword.
  for (genvar g = 0; g < SYMS_PER_CW; g++) begin : g_sym
    assign w_syms[g] = r_cw[CW_W-1-SYM_W*g -: SYM_W];
  end

  assign w_last = (r_sym_idx == IDX_LAST) && (r_cyc == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw      <= '0;
      r_sym_idx <= '0;
      r_cyc     <= '0;
    end else if (w_accept) begin
      r_cw      <= w_cw;
      r_sym_idx <= '0;
      r_cyc     <= '0;
    end else if (r_state == SEND) begin
      if (r_cyc == CYC_LAST) begin
        r_cyc     <= '0;
        r_sym_idx <= r_sym_idx + 3'd1;
      end else begin
        r_cyc     <= r_cyc + CYC_W'(1);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    sym       = '0;
    sym_first = 1'b0;
    tx_done   = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SEND;
      end
      SEND: begin
        sym_valid = 1'b1;
        busy      = 1'b1;
        sym       = w_syms[r_sym_idx];
        sym_first = (r_sym_idx == 3'd0) && (r_cyc == '0);
        tx_done   = w_last;
        // Accepting on the final clock chains the next codeword with no gap.
        in_ready  = w_last;
        if (w_last && !in_valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_accept = in_valid && in_ready;
  end

endmodule
